// File: rtl/h264_top_skeleton.sv
// ---------------------------------------------------------------------------
// h264_top_skeleton
//   Top-level skeleton of the intra-frame H.264 encoder path. Collects one
//   macroblock (64 luma words + 32 chroma words) into a 96-word buffer, then
//   streams it out as one QP header byte followed by 384 raw sample bytes.
//   A one-cycle tobytes_DONE pulse follows the last macroblock of a frame.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   NEWSLICE                clears the MB position while the buffer is idle
//   NEWLINE                 start of MB row (no functional effect)
//   qp[5:0]                 quantiser, sampled in the header-byte cycle
//   xbuffer_DONE            buffer empty and idle
//   intra4x4_*              luma word input (READYI/STROBEI/DATAI)
//   intra8x8cc_*            chroma word input (READYI/STROBEI/DATAI)
//   tobytes_BYTE/STROBE     output byte stream
//   tobytes_DONE            end-of-frame pulse
// ---------------------------------------------------------------------------
module h264_top_skeleton #(
    parameter int IMGWIDTH  = 352,
    parameter int IMGHEIGHT = 288,
    parameter int IWBITS    = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        NEWSLICE,
    input  logic        NEWLINE,
    input  logic [5:0]  qp,
    output logic        xbuffer_DONE,
    output logic        intra4x4_READYI,
    input  logic        intra4x4_STROBEI,
    input  logic [31:0] intra4x4_DATAI,
    output logic        intra8x8cc_READYI,
    input  logic        intra8x8cc_STROBEI,
    input  logic [31:0] intra8x8cc_DATAI,
    output logic [7:0]  tobytes_BYTE,
    output logic        tobytes_STROBE,
    output logic        tobytes_DONE
);

    localparam int MBROWS = IMGHEIGHT / 16;
    localparam int YBITS  = (MBROWS > 1) ? $clog2(MBROWS) : 1;
    localparam logic [IWBITS-1:0] LAST_X = IWBITS'(IMGWIDTH - 16);
    localparam logic [YBITS-1:0]  LAST_Y = YBITS'(MBROWS - 1);

    typedef enum logic [1:0] {S_FILL, S_OUT, S_DONE} state_t;

    state_t state, state_n;

    logic [31:0]       buf_mem [0:95];
    logic [6:0]        luma_cnt;
    logic [5:0]        chroma_cnt;
    logic [8:0]        byte_cnt;
    // MB position within the frame; together these form the MB counter.
    // mb_x is the pixel column of the current MB.
    logic [IWBITS-1:0] mb_x;
    logic [YBITS-1:0]  mb_y;

    logic luma_acc, chroma_acc, buf_full, last_byte, last_mb;
    logic [8:0]  byte_idx;
    logic [31:0] rd_word;

    logic unused_newline;
    assign unused_newline = NEWLINE;

    assign luma_acc   = intra4x4_READYI & intra4x4_STROBEI;
    assign chroma_acc = intra8x8cc_READYI & intra8x8cc_STROBEI;
    assign buf_full   = (luma_cnt == 7'd64) && (chroma_cnt == 6'd32);
    assign last_byte  = (byte_cnt == 9'd384);
    assign last_mb    = (mb_x == LAST_X) && (mb_y == LAST_Y);

    // Byte 0 is the header, so sample bytes are offset by one.
    assign byte_idx = byte_cnt - 9'd1;
    assign rd_word  = buf_mem[byte_idx[8:2]];

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FILL;
        else        state <= state_n;
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_n           = state;
        intra4x4_READYI   = 1'b0;
        intra8x8cc_READYI = 1'b0;
        xbuffer_DONE      = 1'b0;
        tobytes_STROBE    = 1'b0;
        tobytes_DONE      = 1'b0;
        tobytes_BYTE      = 8'd0;
        case (state)
            S_FILL: begin
                intra4x4_READYI   = (luma_cnt < 7'd64);
                intra8x8cc_READYI = (chroma_cnt < 6'd32);
                xbuffer_DONE      = (luma_cnt == 7'd0) && (chroma_cnt == 6'd0);
                if (buf_full) state_n = S_OUT;
            end
            S_OUT: begin
                tobytes_STROBE = 1'b1;
                if (byte_cnt == 9'd0) tobytes_BYTE = {2'b00, qp};
                else                  tobytes_BYTE = rd_word[8*byte_idx[1:0] +: 8];
                if (last_byte) state_n = last_mb ? S_DONE : S_FILL;
            end
            S_DONE: begin
                tobytes_DONE = 1'b1;
                state_n      = S_FILL;
            end
            default: state_n = S_FILL;
        endcase
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luma_cnt   <= '0;
            chroma_cnt <= '0;
            byte_cnt   <= '0;
            mb_x       <= '0;
            mb_y       <= '0;
        end else begin
            if (luma_acc)   luma_cnt   <= luma_cnt + 7'd1;
            if (chroma_acc) chroma_cnt <= chroma_cnt + 6'd1;
            if (xbuffer_DONE && NEWSLICE) begin
                mb_x <= '0;
                mb_y <= '0;
            end
            if (state == S_OUT) begin
                if (last_byte) begin
                    byte_cnt   <= '0;
                    luma_cnt   <= '0;
                    chroma_cnt <= '0;
                    if (mb_x == LAST_X) begin
                        mb_x <= '0;
                        mb_y <= mb_y + YBITS'(1);
                    end else begin
                        mb_x <= mb_x + IWBITS'(16);
                    end
                end else begin
                    byte_cnt <= byte_cnt + 9'd1;
                end
            end
            if (state == S_DONE) begin
                mb_x <= '0;
                mb_y <= '0;
            end
        end
    end

    // ---------------- sample buffer (no reset needed) ----------------
    // Luma fills 0..63, chroma fills 64..95, both in arrival order.
    always_ff @(posedge clk) begin
        if (luma_acc)   buf_mem[{1'b0, luma_cnt[5:0]}]    <= intra4x4_DATAI;
        if (chroma_acc) buf_mem[{2'b10, chroma_cnt[4:0]}] <= intra8x8cc_DATAI;
    end

endmodule

// File: tb/tb_h264_top_skeleton.sv
module tb_h264_top_skeleton;

    localparam int W     = 32;
    localparam int H     = 16;
    localparam int TOTAL = (W / 16) * (H / 16);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        NEWSLICE = 1'b0, NEWLINE = 1'b0;
    logic [5:0]  qp = '0;
    logic        xbuffer_DONE, intra4x4_READYI, intra8x8cc_READYI;
    logic        intra4x4_STROBEI = 1'b0, intra8x8cc_STROBEI = 1'b0;
    logic [31:0] intra4x4_DATAI = '0, intra8x8cc_DATAI = '0;
    logic [7:0]  tobytes_BYTE;
    logic        tobytes_STROBE, tobytes_DONE;

    h264_top_skeleton #(.IMGWIDTH(W), .IMGHEIGHT(H), .IWBITS(9)) dut (
        .clk(clk), .rst_n(rst_n), .NEWSLICE(NEWSLICE), .NEWLINE(NEWLINE), .qp(qp),
        .xbuffer_DONE(xbuffer_DONE),
        .intra4x4_READYI(intra4x4_READYI), .intra4x4_STROBEI(intra4x4_STROBEI),
        .intra4x4_DATAI(intra4x4_DATAI),
        .intra8x8cc_READYI(intra8x8cc_READYI), .intra8x8cc_STROBEI(intra8x8cc_STROBEI),
        .intra8x8cc_DATAI(intra8x8cc_DATAI),
        .tobytes_BYTE(tobytes_BYTE), .tobytes_STROBE(tobytes_STROBE),
        .tobytes_DONE(tobytes_DONE)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one MB is a luma image and a chroma image in raster
    // order; the expected stream is the header followed by both, in order.
    logic [7:0] lb [256];
    logic [7:0] cb [128];
    logic [7:0] want_b [385];
    int         mb_idx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] lw(input int i);
        return {lb[4*i+3], lb[4*i+2], lb[4*i+1], lb[4*i]};
    endfunction

    function automatic logic [31:0] cw(input int i);
        return {cb[4*i+3], cb[4*i+2], cb[4*i+1], cb[4*i]};
    endfunction

    task automatic drive_mb(input bit lfirst, input bit ns_mid);
        int li = 0, ci = 0, guard = 0;
        bit sl, sc;
        logic rl, rc;
        while ((li < 64 || ci < 32) && guard < 3000) begin
            @(negedge clk);
            guard++;
            rl = intra4x4_READYI;
            rc = intra8x8cc_READYI;
            if (lfirst) begin
                // junk luma strobes keep coming once luma is complete
                sl = (li < 64) ? ($urandom_range(0, 3) != 0) : 1'b1;
                sc = (li == 64) && (ci < 32) && ($urandom_range(0, 3) != 0);
                if (li == 64) begin
                    check("luma_full_ready", rl, 1'b0);
                    check("chroma_pending_ready", rc, 1'b1);
                    check("no_strobe_pending", tobytes_STROBE, 1'b0);
                end
            end else begin
                sl = (li < 64) && ($urandom_range(0, 2) != 0);
                sc = (ci < 32) && ($urandom_range(0, 2) != 0);
            end
            NEWSLICE           = ns_mid && (li == 10);
            NEWLINE            = 1'($urandom_range(0, 1));
            intra4x4_STROBEI   = sl;
            intra4x4_DATAI     = (li < 64) ? lw(li) : $urandom();
            intra8x8cc_STROBEI = sc;
            intra8x8cc_DATAI   = (ci < 32) ? cw(ci) : $urandom();
            if (sl && rl && li < 64) li++;
            if (sc && rc) ci++;
        end
        if (guard >= 3000) check("input_timeout", 32'(li + ci), 32'd96);
    endtask

    task automatic collect(input bit want_done, input int abort_at);
        int k = 0;
        @(negedge clk);
        intra4x4_STROBEI = 1'b0; intra8x8cc_STROBEI = 1'b0;
        intra4x4_DATAI = '0; intra8x8cc_DATAI = '0; NEWSLICE = 1'b0;
        check("latency_early", tobytes_STROBE, 1'b0);
        check("byte_zero_idle", tobytes_BYTE, 8'd0);
        @(negedge clk);
        check("latency_2", tobytes_STROBE, 1'b1);
        while (!tobytes_STROBE && k < 20) begin @(negedge clk); k++; end
        if (!tobytes_STROBE) begin
            check("strobe_timeout", tobytes_STROBE, 1'b1);
            return;
        end
        for (int b = 0; b < 385; b++) begin
            check($sformatf("strobe%0d", b), tobytes_STROBE, 1'b1);
            check($sformatf("byte%0d", b), tobytes_BYTE, want_b[b]);
            check($sformatf("done_early%0d", b), tobytes_DONE, 1'b0);
            if (b == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("abort_strobe", tobytes_STROBE, 1'b0);
                check("abort_byte", tobytes_BYTE, 8'd0);
                check("abort_ready_l", intra4x4_READYI, 1'b1);
                check("abort_ready_c", intra8x8cc_READYI, 1'b1);
                check("abort_xbuf", xbuffer_DONE, 1'b1);
                @(negedge clk);
                @(negedge clk);
                check("abort_hold_strobe", tobytes_STROBE, 1'b0);
                rst_n = 1'b1;
                mb_idx = 0;
                return;
            end
            @(negedge clk);
        end
        check("strobe_end", tobytes_STROBE, 1'b0);
        check("byte_end", tobytes_BYTE, 8'd0);
        check("done_pulse", tobytes_DONE, want_done);
        @(negedge clk);
        check("done_one_cycle", tobytes_DONE, 1'b0);
        check("xbuf_after", xbuffer_DONE, 1'b1);
        check("ready_l_after", intra4x4_READYI, 1'b1);
        check("ready_c_after", intra8x8cc_READYI, 1'b1);
    endtask

    task automatic run_mb(input logic [5:0] q, input bit pattern, input bit lfirst,
                          input bit ns_mid, input int abort_at);
        bit want_done;
        qp = q;
        for (int n = 0; n < 256; n++) lb[n] = pattern ? 8'(n) : 8'($urandom());
        for (int m = 0; m < 128; m++) cb[m] = pattern ? 8'(8'h80 + m) : 8'($urandom());
        want_b[0] = {2'b00, q};
        for (int n = 0; n < 256; n++) want_b[1 + n] = lb[n];
        for (int m = 0; m < 128; m++) want_b[257 + m] = cb[m];
        want_done = (mb_idx + 1 == TOTAL);
        drive_mb(lfirst, ns_mid);
        collect(want_done, abort_at);
        if (abort_at < 0) mb_idx = want_done ? 0 : mb_idx + 1;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready_l", intra4x4_READYI, 1'b1);
        check("rst_ready_c", intra8x8cc_READYI, 1'b1);
        check("rst_xbuf", xbuffer_DONE, 1'b1);
        check("rst_strobe", tobytes_STROBE, 1'b0);
        check("rst_done", tobytes_DONE, 1'b0);
        check("rst_byte", tobytes_BYTE, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MB 0: known pattern, qp 28, interleaved ports, no DONE
        run_mb(6'd28, 1'b1, 1'b0, 1'b0, -1);
        // MB 1: luma first with junk strobes, NEWSLICE mid-fill ignored, DONE
        run_mb(6'd28, 1'b0, 1'b1, 1'b1, -1);
        // new frame with qp 40 -> header 0x28
        run_mb(6'd40, 1'b0, 1'b0, 1'b0, -1);
        // NEWSLICE while idle restarts the frame position
        @(negedge clk);
        check("xbuf_idle", xbuffer_DONE, 1'b1);
        NEWSLICE = 1'b1;
        @(negedge clk);
        NEWSLICE = 1'b0;
        mb_idx = 0;
        run_mb(6'($urandom_range(0, 51)), 1'b0, 1'b0, 1'b0, -1);
        // abort with reset at byte 100, then a full frame from a clean state
        run_mb(6'($urandom_range(0, 51)), 1'b0, 1'b0, 1'b0, 100);
        @(negedge clk);
        run_mb(6'($urandom_range(0, 51)), 1'b0, 1'b1, 1'b0, -1);
        run_mb(6'($urandom_range(0, 51)), 1'b0, 1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/h264_top_skeleton.md
Name: h264_top_skeleton

Overview:
Top-level skeleton of the intra-frame H.264 encoder path. It accepts raster luma and chroma sample words from the 4x4-luma and 8x8-chroma input ports and assembles one macroblock (MB) at a time in an internal buffer. Each completed MB is serialised as a byte stream (one QP header byte, then 384 raw samples) to the byte writer. A one-cycle DONE pulse marks the end of each frame.

Parameters:
IMGWIDTH, 352, luma width in pixels; multiple of 16.
IMGHEIGHT, 288, luma height in pixels; multiple of 16.
IWBITS, 9, width of pixel-column counters; must satisfy 2^IWBITS > IMGWIDTH.

Ports:
clk  in  1  single system clock; all logic on its rising edge.
rst_n  in  1  asynchronous active-low reset.
NEWSLICE  in  1  start of frame/slice; clears the MB counter while idle.
NEWLINE  in  1  start of an MB row; reserved, no functional effect.
qp  in  6  quantiser value, sampled when a header byte is emitted.
xbuffer_DONE  out  1  MB buffer empty and idle.
intra4x4_READYI  out  1  luma port can accept a burst.
intra4x4_STROBEI  in  1  luma word valid.
intra4x4_DATAI  in  32  4 luma pixels; [7:0] is the leftmost pixel.
intra8x8cc_READYI  out  1  chroma port can accept a burst.
intra8x8cc_STROBEI  in  1  chroma word valid.
intra8x8cc_DATAI  in  32  4 chroma pixels; [7:0] is the leftmost pixel.
tobytes_BYTE  out  8  output byte.
tobytes_STROBE  out  1  tobytes_BYTE valid this cycle.
tobytes_DONE  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Storage: 96 x 32-bit word buffer.
  - Luma words at addresses 0..63, written in arrival order.
  - Chroma words at addresses 64..95.
  - Counters: luma_cnt (0..64), chroma_cnt (0..32).
- Luma input order:
  - A burst is 8 strobed words: two 16-pixel rows, 4 words per row, left to right.
  - 8 bursts make one 16x16 MB, stored raster order.
- Chroma input order:
  - A burst is 8 words: 4 rows of 8 pixels, 2 words per row.
  - Bursts 0-1 are Cb rows 0-7; bursts 2-3 are Cr rows 0-7.
- States: FILL, OUT, DONE.
- FILL:
  - Each cycle with STROBEI high and the matching count below its limit stores the word and increments the count.
  - Strobes arriving at a full count are ignored.
  - Both ports may strobe in the same cycle, independently.
  - intra4x4_READYI = FILL && luma_cnt < 64.
  - intra8x8cc_READYI = FILL && chroma_cnt < 32.
- FILL to OUT when luma_cnt == 64 and chroma_cnt == 32; both READYI drop in that cycle.
- OUT:
  - tobytes_STROBE is high for exactly 385 consecutive cycles, starting the cycle after entry.
  - Byte 0 is {2'b00, qp}, with qp sampled in that cycle.
  - Bytes 1..384 are the buffer bytes in address order, byte lane [7:0] first: 256 luma, then 64 Cb, then 64 Cr.
  - tobytes_BYTE is 0 whenever STROBE is low.
- After the last byte:
  - Counts clear and mb_cnt increments.
  - If mb_cnt reaches (IMGWIDTH/16)*(IMGHEIGHT/16), go to DONE; otherwise return to FILL.
- DONE: tobytes_DONE high for exactly one cycle, mb_cnt clears to 0, then FILL.
- xbuffer_DONE = FILL && luma_cnt == 0 && chroma_cnt == 0.
- NEWSLICE:
  - Clears mb_cnt only while xbuffer_DONE is high.
  - Ignored at all other times; partial data is never discarded.
- Reset (asynchronous, active-low):
  - State FILL; all counters 0.
  - Outputs: READYI both 1, xbuffer_DONE 1, tobytes_STROBE 0, tobytes_DONE 0, tobytes_BYTE 0.
  - Reset asserted mid-MB or mid-OUT aborts the MB immediately; no further strobes.
- Output-side latency: first STROBE exactly 2 cycles after the cycle the final input word is accepted.

Test Plan:
- Reset: hold rst_n=0 -> READYI both 1, xbuffer_DONE 1, STROBE/DONE 0.
- IMGWIDTH=32, IMGHEIGHT=16, qp=28, luma byte n = n&0xFF, chroma byte m = 0x80+m -> 385 strobed bytes: 0x1C, 0x00..0xFF, then 0x80..0xFF; no DONE after MB 0; DONE pulses once after MB 1's last byte.
- Luma complete, chroma still pending -> intra4x4_READYI=0, intra8x8cc_READYI=1, no STROBE until the 32nd chroma word plus 2 cycles.
- Extra strobes with luma_cnt=64 -> no change to stored data or to the byte stream.
- Change qp to 40 between MBs -> header byte 0x28 on the next MB.
- rst_n pulsed during OUT at byte 100 -> STROBE drops at once; the next MB starts clean with mb_cnt=0.
